kpn_queue_write_arbiter: RTL

Round-robin write arbiter that shares the write port of one KPN channel queue between NUM_REQ producer processes. The arbiter grants one producer at a time, forwards that producer's word and write strobe to the queue, and respects the queue's full flag. A grant lasts for a bounded burst of words. The block sits between the producer process nodes and the write side of the channel FIFO in the fixed-point KPN datapath.

---
 rtl/kpn_queue_write_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/kpn_queue_write_arbiter.sv
// Round-robin write arbiter sharing one KPN channel queue write port among
// NUM_REQ producers; grants last up to BURST_LEN words and honour queue full.
module kpn_queue_write_arbiter #(
  parameter int BITS_NUMBER = 16,
  parameter int NUM_REQ     = 4,
  parameter int BURST_LEN   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BITS_NUMBER-1:0] data_in,
  input  logic                           full,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           wr,
  output logic [BITS_NUMBER-1:0]         output_1,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam int         PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAST = 4'(BURST_LEN - 1);

  state_t             r_state, w_state_nx;
  logic [NUM_REQ-1:0] r_grant, w_grant_nx;
  logic [PW-1:0]      r_ptr, w_ptr_nx;
  logic [3:0]         r_bcnt, w_bcnt_nx;
  logic [PW-1:0]      w_winner;
  logic               w_owner_req;
  logic               w_xfer;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int off);
    return PW'((int'(p) + off) % NUM_REQ);
  endfunction

  // Scan from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    w_winner = r_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[rr_idx(r_ptr, i)]) w_winner = rr_idx(r_ptr, i);
    end
  end

  assign w_owner_req = |(r_grant & req);
  assign w_xfer      = w_owner_req & ~full;

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ptr_nx   = r_ptr;
    w_bcnt_nx  = r_bcnt;
    case (r_state)
      IDLE: begin
        w_grant_nx = '0;
        if (|req) begin
          w_grant_nx[w_winner] = 1'b1;
          w_ptr_nx             = w_winner;
          w_bcnt_nx            = 4'd0;
          w_state_nx           = GRANT;
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_grant_nx = '0;
          w_state_nx = RELEASE;
        end else if (w_xfer) begin
          w_bcnt_nx = r_bcnt + 4'd1;
          if (r_bcnt == LAST) begin
            w_grant_nx = '0;
            w_state_nx = RELEASE;
          end
        end
      end
      RELEASE: begin
        w_grant_nx = '0;
        w_state_nx = IDLE;
      end
      default: begin
        w_grant_nx = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_bcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_ptr   <= w_ptr_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  // One-hot grant makes an OR of masked slices a plain mux; zero when idle.
  always_comb begin
    output_1 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) output_1 = output_1 | data_in[k*BITS_NUMBER +: BITS_NUMBER];
    end
  end

  assign grant = r_grant;
  assign wr    = w_owner_req & ~full;
  assign busy  = (r_state == GRANT);

endmodule
